// File: rtl/cdb_rr_arbiter.sv
// CDB arbiter: each cycle grants up to NUM_CDB finished functional units (starved units first,
// then round-robin or fixed priority) and registers the winners' results onto the CDB.
module cdb_rr_arbiter #(
  parameter int NUM_CDB      = 3,
  parameter int NUM_FU       = 8,
  parameter int PRF_BITS     = 6,
  parameter int ROB_BITS     = 5,
  parameter int XLEN         = 32,
  parameter int ARB_MODE     = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               nuke,
  input  logic                               cdb_stall,
  input  logic [NUM_FU-1:0]                  fu_valid,
  input  logic [NUM_FU-1:0]                  fu_ready,
  input  logic [NUM_FU-1:0][PRF_BITS-1:0]    fu_dest_prf,
  input  logic [NUM_FU-1:0][ROB_BITS-1:0]    fu_rob_entry,
  input  logic [NUM_FU-1:0][XLEN-1:0]        fu_branch_address,
  input  logic [NUM_FU-1:0][XLEN-1:0]        fu_value,
  input  logic [NUM_FU-1:0]                  fu_value_valid,
  output logic [NUM_FU-1:0]                  fu_sel,
  output logic [NUM_FU-1:0]                  fu_avail,
  output logic [NUM_CDB-1:0]                 cdb_valid,
  output logic [NUM_CDB-1:0][PRF_BITS-1:0]   cdb_dest_prf,
  output logic [NUM_CDB-1:0][ROB_BITS-1:0]   cdb_rob_entry,
  output logic [NUM_CDB-1:0][XLEN-1:0]       cdb_branch_address,
  output logic [NUM_CDB-1:0][XLEN-1:0]       cdb_value,
  output logic [NUM_CDB-1:0]                 cdb_value_valid
);

  localparam int         PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic [NUM_FU-1:0]             sel;
    logic [NUM_CDB-1:0]            vld;
    logic [NUM_CDB-1:0][PTR_W-1:0] idx;
    logic                          rot_any;
    logic [PTR_W-1:0]              rot_last;
  } arb_t;

  logic [PTR_W-1:0]                ptr;
  logic [PTR_W-1:0]                ptr_nxt;
  logic [NUM_FU-1:0][3:0]          wait_cnt;
  logic [NUM_FU-1:0][3:0]          wait_nxt;
  arb_t                            arb;
  logic [NUM_CDB-1:0][PRF_BITS-1:0] nxt_dest;
  logic [NUM_CDB-1:0][ROB_BITS-1:0] nxt_rob;
  logic [NUM_CDB-1:0][XLEN-1:0]     nxt_br;
  logic [NUM_CDB-1:0][XLEN-1:0]     nxt_val;
  logic [NUM_CDB-1:0]               nxt_vv;

  // Slots are claimed through a one-hot slot marker so slot order equals grant order.
  function automatic arb_t arbitrate(input logic [NUM_FU-1:0]      req,
                                     input logic [PTR_W-1:0]       start,
                                     input logic [NUM_FU-1:0][3:0] cnt);
    arb_t               r;
    logic [NUM_CDB-1:0] slot_oh;
    logic [PTR_W-1:0]   pos;
    int                 idx;
    r       = '0;
    slot_oh = NUM_CDB'(1);
    for (int i = 0; i < NUM_FU; i++) begin
      if (req[i] && (cnt[i] >= LIMIT) && (slot_oh != '0)) begin
        r.sel[i] = 1'b1;
        for (int s = 0; s < NUM_CDB; s++) begin
          if (slot_oh[s]) begin
            r.vld[s] = 1'b1;
            r.idx[s] = PTR_W'(i);
          end
        end
        slot_oh = slot_oh << 1'b1;
      end
    end
    for (int k = 0; k < NUM_FU; k++) begin
      idx = (ARB_MODE == 1) ? int'(start) + k : k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      pos = PTR_W'(idx);
      if (req[pos] && !r.sel[pos] && (slot_oh != '0)) begin
        r.sel[pos] = 1'b1;
        for (int s = 0; s < NUM_CDB; s++) begin
          if (slot_oh[s]) begin
            r.vld[s] = 1'b1;
            r.idx[s] = pos;
          end
        end
        slot_oh    = slot_oh << 1'b1;
        r.rot_any  = 1'b1;
        r.rot_last = pos;
      end
    end
    return r;
  endfunction

  // Grant selection; reset, nuke and stall suppress every grant.
  always_comb begin
    arb = '0;
    if (reset || nuke || cdb_stall) begin
      arb = '0;
    end else begin
      arb = arbitrate(fu_valid, ptr, wait_cnt);
    end
  end

  assign fu_sel   = arb.sel;
  assign fu_avail = fu_ready | arb.sel;

  // Winner field mux; unfilled slots carry all-zero data.
  always_comb begin
    nxt_dest = '0;
    nxt_rob  = '0;
    nxt_br   = '0;
    nxt_val  = '0;
    nxt_vv   = '0;
    for (int s = 0; s < NUM_CDB; s++) begin
      if (arb.vld[s]) begin
        nxt_dest[s] = fu_dest_prf[arb.idx[s]];
        nxt_rob[s]  = fu_rob_entry[arb.idx[s]];
        nxt_br[s]   = fu_branch_address[arb.idx[s]];
        nxt_val[s]  = fu_value[arb.idx[s]];
        nxt_vv[s]   = fu_value_valid[arb.idx[s]];
      end else begin
        nxt_dest[s] = '0;
        nxt_rob[s]  = '0;
        nxt_br[s]   = '0;
        nxt_val[s]  = '0;
        nxt_vv[s]   = 1'b0;
      end
    end
  end

  // Next rotation pointer and starvation counters for an active (non-stall, non-nuke) cycle.
  always_comb begin
    ptr_nxt  = ptr;
    wait_nxt = wait_cnt;
    if ((ARB_MODE == 1) && arb.rot_any) begin
      if (arb.rot_last == PTR_W'(NUM_FU - 1)) begin
        ptr_nxt = '0;
      end else begin
        ptr_nxt = arb.rot_last + 1'b1;
      end
    end else begin
      ptr_nxt = ptr;
    end
    for (int i = 0; i < NUM_FU; i++) begin
      if (arb.sel[i] || !fu_valid[i]) begin
        wait_nxt[i] = 4'd0;
      end else if (wait_cnt[i] < LIMIT) begin
        wait_nxt[i] = wait_cnt[i] + 4'd1;
      end else begin
        wait_nxt[i] = wait_cnt[i];
      end
    end
  end

  // State and CDB registers: reset clears all, nuke clears CDB and counters but keeps ptr, stall holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr                <= '0;
      wait_cnt           <= '0;
      cdb_valid          <= '0;
      cdb_dest_prf       <= '0;
      cdb_rob_entry      <= '0;
      cdb_branch_address <= '0;
      cdb_value          <= '0;
      cdb_value_valid    <= '0;
    end else if (nuke) begin
      wait_cnt           <= '0;
      cdb_valid          <= '0;
      cdb_dest_prf       <= '0;
      cdb_rob_entry      <= '0;
      cdb_branch_address <= '0;
      cdb_value          <= '0;
      cdb_value_valid    <= '0;
    end else if (!cdb_stall) begin
      ptr                <= ptr_nxt;
      wait_cnt           <= wait_nxt;
      cdb_valid          <= arb.vld;
      cdb_dest_prf       <= nxt_dest;
      cdb_rob_entry      <= nxt_rob;
      cdb_branch_address <= nxt_br;
      cdb_value          <= nxt_val;
      cdb_value_valid    <= nxt_vv;
    end
  end

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Bench for cdb_rr_arbiter: a round-robin instance (limit 4) and a fixed-priority instance (limit 2)
// share stimulus and are compared against a queue-based reference model.
module tb_cdb_rr_arbiter;

  localparam int NC = 2;
  localparam int NF = 4;
  localparam int PB = 6;
  localparam int RB = 5;
  localparam int XL = 32;
  localparam int SW = 1 + PB + RB + XL + XL + 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                 reset = 1'b1;
  logic                 nuke = 1'b0;
  logic                 cdb_stall = 1'b0;
  logic [NF-1:0]        fu_valid = '0;
  logic [NF-1:0]        fu_ready = '0;
  logic [NF-1:0]        fu_value_valid = '0;
  logic [NF-1:0][PB-1:0] fu_dest_prf = '0;
  logic [NF-1:0][RB-1:0] fu_rob_entry = '0;
  logic [NF-1:0][XL-1:0] fu_branch_address = '0;
  logic [NF-1:0][XL-1:0] fu_value = '0;

  logic [NF-1:0]         rr_sel, rr_avail, fp_sel, fp_avail;
  logic [NC-1:0]         rr_cdb_valid, rr_vv, fp_cdb_valid, fp_vv;
  logic [NC-1:0][PB-1:0] rr_dest, fp_dest;
  logic [NC-1:0][RB-1:0] rr_rob, fp_rob;
  logic [NC-1:0][XL-1:0] rr_br, rr_val, fp_br, fp_val;

  cdb_rr_arbiter #(.NUM_CDB(NC), .NUM_FU(NF), .PRF_BITS(PB), .ROB_BITS(RB), .XLEN(XL),
                   .ARB_MODE(1), .STARVE_LIMIT(4)) dut_rr (
    .clock(clock), .reset(reset), .nuke(nuke), .cdb_stall(cdb_stall),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_dest_prf(fu_dest_prf),
    .fu_rob_entry(fu_rob_entry), .fu_branch_address(fu_branch_address),
    .fu_value(fu_value), .fu_value_valid(fu_value_valid),
    .fu_sel(rr_sel), .fu_avail(rr_avail), .cdb_valid(rr_cdb_valid),
    .cdb_dest_prf(rr_dest), .cdb_rob_entry(rr_rob), .cdb_branch_address(rr_br),
    .cdb_value(rr_val), .cdb_value_valid(rr_vv));

  cdb_rr_arbiter #(.NUM_CDB(NC), .NUM_FU(NF), .PRF_BITS(PB), .ROB_BITS(RB), .XLEN(XL),
                   .ARB_MODE(0), .STARVE_LIMIT(2)) dut_fp (
    .clock(clock), .reset(reset), .nuke(nuke), .cdb_stall(cdb_stall),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_dest_prf(fu_dest_prf),
    .fu_rob_entry(fu_rob_entry), .fu_branch_address(fu_branch_address),
    .fu_value(fu_value), .fu_value_valid(fu_value_valid),
    .fu_sel(fp_sel), .fu_avail(fp_avail), .cdb_valid(fp_cdb_valid),
    .cdb_dest_prf(fp_dest), .cdb_rob_entry(fp_rob), .cdb_branch_address(fp_br),
    .cdb_value(fp_val), .cdb_value_valid(fp_vv));

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state, index 0 = round-robin instance, 1 = fixed-priority instance.
  int          m_ptr [2];
  int          m_wait [2][NF];
  logic [SW-1:0] m_cdb [2][NC];
  logic [NF-1:0] m_sel [2];
  int          m_win [2][NC];
  int          m_rot_last [2];
  bit          m_rot_any [2];

  function automatic int mode_of(input int c);
    return (c == 0) ? 1 : 0;
  endfunction

  function automatic int lim_of(input int c);
    return (c == 0) ? 4 : 2;
  endfunction

  function automatic logic [SW-1:0] pack_fu(input int i);
    return {1'b1, fu_dest_prf[i], fu_rob_entry[i], fu_branch_address[i], fu_value[i], fu_value_valid[i]};
  endfunction

  function automatic logic [SW-1:0] obs_slot(input int c, input int s);
    if (c == 0) return {rr_cdb_valid[s], rr_dest[s], rr_rob[s], rr_br[s], rr_val[s], rr_vv[s]};
    return {fp_cdb_valid[s], fp_dest[s], fp_rob[s], fp_br[s], fp_val[s], fp_vv[s]};
  endfunction

  function automatic logic [NF-1:0] obs_sel(input int c);
    return (c == 0) ? rr_sel : fp_sel;
  endfunction

  function automatic logic [NF-1:0] obs_avail(input int c);
    return (c == 0) ? rr_avail : fp_avail;
  endfunction

  function automatic int obs_ptr(input int c);
    return (c == 0) ? int'(dut_rr.ptr) : int'(dut_fp.ptr);
  endfunction

  function automatic int obs_wait(input int c, input int i);
    return (c == 0) ? int'(dut_rr.wait_cnt[i]) : int'(dut_fp.wait_cnt[i]);
  endfunction

  // Winner list: starved requesters in index order, then the scan order, truncated to NC.
  task automatic model_eval(input int c);
    int order[$];
    int i;
    m_sel[c] = '0;
    m_rot_any[c] = 1'b0;
    m_rot_last[c] = 0;
    for (int s = 0; s < NC; s++) m_win[c][s] = -1;
    if (!(reset || nuke || cdb_stall)) begin
      for (int k = 0; k < NF; k++)
        if (fu_valid[k] && m_wait[c][k] >= lim_of(c)) order.push_back(k);
      while (order.size() > NC) void'(order.pop_back());
      foreach (order[j]) m_sel[c][order[j]] = 1'b1;
      for (int k = 0; k < NF; k++) begin
        i = (mode_of(c) == 1) ? (m_ptr[c] + k) % NF : k;
        if (fu_valid[i] && !m_sel[c][i] && order.size() < NC) begin
          order.push_back(i);
          m_sel[c][i] = 1'b1;
          m_rot_any[c] = 1'b1;
          m_rot_last[c] = i;
        end
      end
      foreach (order[j]) m_win[c][j] = order[j];
    end
  endtask

  task automatic model_commit(input int c);
    if (reset) begin
      m_ptr[c] = 0;
      for (int i = 0; i < NF; i++) m_wait[c][i] = 0;
      for (int s = 0; s < NC; s++) m_cdb[c][s] = '0;
    end else if (nuke) begin
      for (int i = 0; i < NF; i++) m_wait[c][i] = 0;
      for (int s = 0; s < NC; s++) m_cdb[c][s] = '0;
    end else if (!cdb_stall) begin
      for (int s = 0; s < NC; s++) m_cdb[c][s] = (m_win[c][s] >= 0) ? pack_fu(m_win[c][s]) : '0;
      for (int i = 0; i < NF; i++) begin
        if (m_sel[c][i] || !fu_valid[i]) m_wait[c][i] = 0;
        else if (m_wait[c][i] < lim_of(c)) m_wait[c][i] = m_wait[c][i] + 1;
      end
      if (mode_of(c) == 1 && m_rot_any[c]) m_ptr[c] = (m_rot_last[c] + 1) % NF;
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NF; i++) begin
      fu_dest_prf[i]       = PB'($urandom);
      fu_rob_entry[i]      = RB'($urandom);
      fu_branch_address[i] = $urandom;
      fu_value[i]          = $urandom;
      fu_value_valid[i]    = 1'($urandom);
    end
    fu_ready = NF'($urandom);
  endtask

  task automatic to_negedge();
    @(negedge clock);
    model_eval(0);
    model_eval(1);
  endtask

  task automatic to_posedge();
    @(posedge clock);
    model_commit(0);
    model_commit(1);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; nuke = 1'b0; cdb_stall = 1'b0; fu_valid = 4'b1111;
    rand_data();
    to_posedge();
    for (int cyc = 0; cyc < 2; cyc++) begin
      to_negedge();
      n_checks++;
      if (rr_sel !== 4'b0000 || fp_sel !== 4'b0000) begin
        n_fail++; $display("FAIL reset_sel: rr=%b fp=%b required 0000", rr_sel, fp_sel);
      end
      to_posedge();
      n_checks++;
      if (rr_cdb_valid !== 2'b00 || fp_cdb_valid !== 2'b00) begin
        n_fail++; $display("FAIL reset_cdb_valid: rr=%b fp=%b required 00", rr_cdb_valid, fp_cdb_valid);
      end
      n_checks++;
      if (obs_ptr(0) !== 0) begin
        n_fail++; $display("FAIL reset_ptr: got %0d required 0", obs_ptr(0));
      end
    end
  endtask

  task automatic test_round_robin();
    reset = 1'b0; fu_valid = 4'b1111;
    rand_data();
    to_negedge();
    n_checks++;
    if (rr_sel !== 4'b0011) begin
      n_fail++; $display("FAIL rr_cycle0_sel: got %b required 0011", rr_sel);
    end
    n_checks++;
    if (rr_avail !== (fu_ready | 4'b0011)) begin
      n_fail++; $display("FAIL rr_cycle0_avail: got %b required %b", rr_avail, fu_ready | 4'b0011);
    end
    n_checks++;
    if (fp_sel !== m_sel[1]) begin
      n_fail++; $display("FAIL fp_cycle0_sel: got %b required %b", fp_sel, m_sel[1]);
    end
    to_posedge();
    n_checks++;
    if (obs_ptr(0) !== 2) begin
      n_fail++; $display("FAIL rr_cycle0_ptr: got %0d required 2", obs_ptr(0));
    end
    n_checks++;
    if (obs_slot(0, 0) !== pack_fu(0) || obs_slot(0, 1) !== pack_fu(1)) begin
      n_fail++; $display("FAIL rr_cycle1_cdb: got %h/%h required %h/%h",
                         obs_slot(0, 0), obs_slot(0, 1), pack_fu(0), pack_fu(1));
    end
    rand_data();
    to_negedge();
    n_checks++;
    if (rr_sel !== 4'b1100) begin
      n_fail++; $display("FAIL rr_cycle1_sel: got %b required 1100", rr_sel);
    end
    to_posedge();
    n_checks++;
    if (obs_ptr(0) !== 0) begin
      n_fail++; $display("FAIL rr_cycle1_ptr: got %0d required 0", obs_ptr(0));
    end
    n_checks++;
    if (obs_slot(0, 0) !== pack_fu(2) || obs_slot(0, 1) !== pack_fu(3)) begin
      n_fail++; $display("FAIL rr_cycle2_cdb: got %h/%h required %h/%h",
                         obs_slot(0, 0), obs_slot(0, 1), pack_fu(2), pack_fu(3));
    end
  endtask

  task automatic test_wrap();
    fu_valid = 4'b0100;
    rand_data();
    to_negedge();
    to_posedge();
    n_checks++;
    if (obs_ptr(0) !== 3) begin
      n_fail++; $display("FAIL wrap_setup_ptr: got %0d required 3", obs_ptr(0));
    end
    fu_valid = 4'b1011;
    rand_data();
    to_negedge();
    n_checks++;
    if (rr_sel !== 4'b1001) begin
      n_fail++; $display("FAIL wrap_sel: got %b required 1001", rr_sel);
    end
    to_posedge();
    n_checks++;
    if (obs_slot(0, 0) !== pack_fu(3) || obs_slot(0, 1) !== pack_fu(0)) begin
      n_fail++; $display("FAIL wrap_cdb: got %h/%h required %h/%h",
                         obs_slot(0, 0), obs_slot(0, 1), pack_fu(3), pack_fu(0));
    end
    n_checks++;
    if (obs_ptr(0) !== 1) begin
      n_fail++; $display("FAIL wrap_ptr: got %0d required 1", obs_ptr(0));
    end
  endtask

  task automatic test_starvation();
    fu_valid = 4'b0000;
    to_negedge();
    to_posedge();
    fu_valid = 4'b0111;
    for (int cyc = 0; cyc < 3; cyc++) begin
      rand_data();
      to_negedge();
      n_checks++;
      if (fp_sel !== ((cyc < 2) ? 4'b0011 : 4'b0101)) begin
        n_fail++; $display("FAIL starve_sel_c%0d: got %b required %b", cyc, fp_sel,
                           (cyc < 2) ? 4'b0011 : 4'b0101);
      end
      to_posedge();
      n_checks++;
      if (obs_wait(1, 2) !== ((cyc < 2) ? cyc + 1 : 0)) begin
        n_fail++; $display("FAIL starve_wait2_c%0d: got %0d required %0d", cyc, obs_wait(1, 2),
                           (cyc < 2) ? cyc + 1 : 0);
      end
    end
    n_checks++;
    if (obs_slot(1, 0) !== pack_fu(2) || obs_slot(1, 1) !== pack_fu(0)) begin
      n_fail++; $display("FAIL starve_cdb: got %h/%h required %h/%h",
                         obs_slot(1, 0), obs_slot(1, 1), pack_fu(2), pack_fu(0));
    end
  endtask

  task automatic test_stall();
    logic [SW-1:0] snap [2][NC];
    int            wsnap [2][NF];
    fu_valid = 4'b1111;
    rand_data();
    to_negedge();
    to_posedge();
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < NC; s++) snap[c][s] = m_cdb[c][s];
      for (int i = 0; i < NF; i++) wsnap[c][i] = m_wait[c][i];
    end
    cdb_stall = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      rand_data();
      to_negedge();
      n_checks++;
      if (rr_sel !== 4'b0000 || fp_sel !== 4'b0000) begin
        n_fail++; $display("FAIL stall_sel: rr=%b fp=%b required 0000", rr_sel, fp_sel);
      end
      n_checks++;
      if (rr_avail !== fu_ready || fp_avail !== fu_ready) begin
        n_fail++; $display("FAIL stall_avail: rr=%b fp=%b required %b", rr_avail, fp_avail, fu_ready);
      end
      to_posedge();
      for (int c = 0; c < 2; c++) begin
        for (int s = 0; s < NC; s++) begin
          n_checks++;
          if (obs_slot(c, s) !== snap[c][s]) begin
            n_fail++; $display("FAIL stall_hold_cdb[%0d][%0d]: got %h required %h", c, s, obs_slot(c, s), snap[c][s]);
          end
        end
        for (int i = 0; i < NF; i++) begin
          n_checks++;
          if (obs_wait(c, i) !== wsnap[c][i]) begin
            n_fail++; $display("FAIL stall_hold_wait[%0d][%0d]: got %0d required %0d", c, i, obs_wait(c, i), wsnap[c][i]);
          end
        end
      end
    end
    cdb_stall = 1'b0;
    to_negedge();
    n_checks++;
    if (rr_sel !== m_sel[0] || fp_sel !== m_sel[1] || rr_sel === 4'b0000) begin
      n_fail++; $display("FAIL stall_release_sel: rr=%b fp=%b required %b %b", rr_sel, fp_sel, m_sel[0], m_sel[1]);
    end
    to_posedge();
  endtask

  task automatic test_nuke();
    int ptr_before;
    fu_valid = 4'b1111;
    rand_data();
    to_negedge();
    to_posedge();
    n_checks++;
    if (rr_cdb_valid !== 2'b11) begin
      n_fail++; $display("FAIL nuke_setup_valid: got %b required 11", rr_cdb_valid);
    end
    ptr_before = m_ptr[0];
    nuke = 1'b1; cdb_stall = 1'b1;
    to_negedge();
    n_checks++;
    if (rr_sel !== 4'b0000 || fp_sel !== 4'b0000) begin
      n_fail++; $display("FAIL nuke_sel: rr=%b fp=%b required 0000", rr_sel, fp_sel);
    end
    to_posedge();
    n_checks++;
    if (rr_cdb_valid !== 2'b00 || fp_cdb_valid !== 2'b00) begin
      n_fail++; $display("FAIL nuke_cdb_valid: rr=%b fp=%b required 00", rr_cdb_valid, fp_cdb_valid);
    end
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < NF; i++) begin
        n_checks++;
        if (obs_wait(c, i) !== 0) begin
          n_fail++; $display("FAIL nuke_wait[%0d][%0d]: got %0d required 0", c, i, obs_wait(c, i));
        end
      end
    n_checks++;
    if (obs_ptr(0) !== ptr_before) begin
      n_fail++; $display("FAIL nuke_ptr: got %0d required %0d", obs_ptr(0), ptr_before);
    end
    nuke = 1'b0; cdb_stall = 1'b0;
  endtask

  task automatic test_reset_midop();
    for (int cyc = 0; cyc < 3; cyc++) begin
      fu_valid = NF'($urandom);
      rand_data();
      to_negedge();
      to_posedge();
    end
    reset = 1'b1; cdb_stall = 1'b1; fu_valid = 4'b1111;
    to_negedge();
    n_checks++;
    if (rr_sel !== 4'b0000 || fp_sel !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_sel: rr=%b fp=%b required 0000", rr_sel, fp_sel);
    end
    to_posedge();
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (obs_slot(c, 0) !== '0 || obs_slot(c, 1) !== '0 || obs_ptr(c) !== 0) begin
        n_fail++; $display("FAIL midreset_state[%0d]: cdb %h/%h ptr %0d required zero", c,
                           obs_slot(c, 0), obs_slot(c, 1), obs_ptr(c));
      end
      for (int i = 0; i < NF; i++) begin
        n_checks++;
        if (obs_wait(c, i) !== 0) begin
          n_fail++; $display("FAIL midreset_wait[%0d][%0d]: got %0d required 0", c, i, obs_wait(c, i));
        end
      end
    end
    reset = 1'b0; cdb_stall = 1'b0;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset     = ($urandom_range(0, 49) == 0);
      nuke      = ($urandom_range(0, 19) == 0);
      cdb_stall = ($urandom_range(0, 7) == 0);
      fu_valid  = NF'($urandom);
      rand_data();
      to_negedge();
      for (int c = 0; c < 2; c++) begin
        n_checks++;
        if (obs_sel(c) !== m_sel[c] || obs_avail(c) !== (fu_ready | m_sel[c])) begin
          n_fail++; $display("FAIL rand_sel[%0d] cyc %0d: sel %b avail %b required %b %b", c, cyc,
                             obs_sel(c), obs_avail(c), m_sel[c], fu_ready | m_sel[c]);
        end
      end
      to_posedge();
      for (int c = 0; c < 2; c++) begin
        for (int s = 0; s < NC; s++) begin
          n_checks++;
          if (obs_slot(c, s) !== m_cdb[c][s]) begin
            n_fail++; $display("FAIL rand_cdb[%0d][%0d] cyc %0d: got %h required %h", c, s, cyc,
                               obs_slot(c, s), m_cdb[c][s]);
          end
        end
        n_checks++;
        if (obs_ptr(c) !== m_ptr[c]) begin
          n_fail++; $display("FAIL rand_ptr[%0d] cyc %0d: got %0d required %0d", c, cyc, obs_ptr(c), m_ptr[c]);
        end
        for (int i = 0; i < NF; i++) begin
          n_checks++;
          if (obs_wait(c, i) !== m_wait[c][i]) begin
            n_fail++; $display("FAIL rand_wait[%0d][%0d] cyc %0d: got %0d required %0d", c, i, cyc,
                               obs_wait(c, i), m_wait[c][i]);
          end
        end
      end
    end
    reset = 1'b0; nuke = 1'b0; cdb_stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_starvation();
    test_stall();
    test_nuke();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
